// File: rtl/shift_rows_stream.sv
// Rijndael ShiftRows / InvShiftRows (NB = 4, 6 or 8 columns), selectable per word.
// The permutation is applied on entry and the result is held in a 2-entry ready/valid FIFO.
module shift_rows_stream #(
    parameter int NB = 4,
    localparam int W = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_state,
    output logic         out_inv,
    output logic [1:0]   occupancy
);

    if (!((NB == 32'sd4) || (NB == 32'sd6) || (NB == 32'sd8))) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    // Row offsets: the 256-bit block uses 0,1,3,4; the narrower blocks use 0,1,2,3.
    function automatic int row_shift(input int r);
        int s;
        case (r)
            32'sd0:  s = 32'sd0;
            32'sd1:  s = 32'sd1;
            32'sd2:  s = (NB == 32'sd8) ? 32'sd3 : 32'sd2;
            32'sd3:  s = (NB == 32'sd8) ? 32'sd4 : 32'sd3;
            default: s = 32'sd0;
        endcase
        return s;
    endfunction

    function automatic logic [W-1:0] permute(input logic [W-1:0] st, input logic inv);
        logic [W-1:0] res;
        int           src_c;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) begin
                    src_c = (c + NB - row_shift(r)) % NB;
                end else begin
                    src_c = (c + row_shift(r)) % NB;
                end
                res[W-1-8*(4*c+r) -: 8] = st[W-1-8*(4*src_c+r) -: 8];
            end
        end
        return res;
    endfunction

    logic [W-1:0] r_head_state;
    logic         r_head_inv;
    logic [W-1:0] r_tail_state;
    logic         r_tail_inv;
    logic [1:0]   r_count;
    logic         r_in_ready;
    logic         r_out_valid;

    logic [W-1:0] w_perm;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    // Handshake qualifiers and transformed input word.
    always_comb begin
        w_perm = permute(in_state, in_inv);
        w_push = in_valid && r_in_ready;
        w_pop  = out_ready && r_out_valid;
    end

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Occupancy, handshake flags and the output-visible head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 2'd0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_head_state <= '0;
            r_head_inv   <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_state <= w_perm;
                        r_head_inv   <= in_inv;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_state <= w_perm;
                        r_head_inv   <= in_inv;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head_state <= r_tail_state;
                        r_head_inv   <= r_tail_inv;
                    end
                end
                default: begin
                    r_head_state <= r_head_state;
                end
            endcase
        end
    end

    // Second entry; never visible on the outputs, so it needs no reset.
    always_ff @(posedge clk) begin
        if ((r_count == 2'd1) && w_push && !w_pop) begin
            r_tail_state <= w_perm;
            r_tail_inv   <= in_inv;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_head_state;
    assign out_inv   = r_head_inv;
    assign occupancy = r_count;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: directed vectors plus random mixed-mode streams for NB=4,6,8,
// scored against a row-rotation reference model.
module tb_shift_rows_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_inv    [3];
    logic         out_ready [3];
    logic [255:0] in_st     [3];
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic         out_inv_w   [3];
    logic [1:0]   occ_w       [3];
    logic [127:0] out4;
    logic [191:0] out6;
    logic [255:0] out8;
    logic [255:0] out_st_w    [3];

    int total = 0;
    int bad   = 0;
    logic [256:0] sb [3][$];
    int nbv [3] = '{4, 6, 8};

    always #5 clk = ~clk;

    assign out_st_w[0] = {128'b0, out4};
    assign out_st_w[1] = {64'b0, out6};
    assign out_st_w[2] = out8;

    shift_rows_stream #(.NB(4)) u_nb4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready_w[0]), .in_state(in_st[0][127:0]), .in_inv(in_inv[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .out_state(out4), .out_inv(out_inv_w[0]),
        .occupancy(occ_w[0])
    );
    shift_rows_stream #(.NB(6)) u_nb6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready_w[1]), .in_state(in_st[1][191:0]), .in_inv(in_inv[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .out_state(out6), .out_inv(out_inv_w[1]),
        .occupancy(occ_w[1])
    );
    shift_rows_stream #(.NB(8)) u_nb8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready_w[2]), .in_state(in_st[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .out_state(out8), .out_inv(out_inv_w[2]),
        .occupancy(occ_w[2])
    );

    // Reference: pull each row out as a queue of bytes and rotate it.
    function automatic logic [255:0] ref_perm(input logic [255:0] st, input int nb, input logic inv);
        byte unsigned row[$];
        logic [255:0] res;
        int s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(st[nb*32-1-8*(4*c+r) -: 8]);
            for (int i = 0; i < s; i++) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) res[nb*32-1-8*(4*c+r) -: 8] = row[c];
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes before the edge, then check state against the model after it.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                sb[k].delete();
            end else begin
                if (out_valid_w[k] && out_ready[k] && sb[k].size() > 0) void'(sb[k].pop_front());
                if (in_valid[k] && in_ready_w[k])
                    sb[k].push_back({in_inv[k], ref_perm(in_st[k], nbv[k], in_inv[k])});
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("occ%0d", k), {258'b0, occ_w[k]}, 260'(sb[k].size()));
            chk($sformatf("out_valid%0d", k), {259'b0, out_valid_w[k]}, {259'b0, sb[k].size() > 0});
            chk($sformatf("in_ready%0d", k), {259'b0, in_ready_w[k]}, {259'b0, sb[k].size() < 2});
            if (sb[k].size() > 0)
                chk($sformatf("head%0d", k), {3'b0, out_inv_w[k], out_st_w[k]}, {3'b0, sb[k][0]});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        for (int i = 0; i < 4; i++) tick();
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b0;
    endtask

    initial begin
        logic [255:0] st8;
        logic [255:0] fwd8;
        logic [63:0]  r2e;
        logic [63:0]  r3e;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_inv[k] = 1'b0; out_ready[k] = 1'b0; in_st[k] = '0;
        end
        tick();
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        rst = 1'b0;
        chk("rst_occ", {258'b0, occ_w[0]}, 260'd0);
        chk("rst_out_valid", {259'b0, out_valid_w[0]}, 260'd0);
        chk("rst_in_ready", {259'b0, in_ready_w[0]}, 260'd1);
        chk("rst_out_state", {4'b0, out_st_w[2]}, 260'd0);
        chk("rst_out_inv", {259'b0, out_inv_w[0]}, 260'd0);

        // Known-answer forward vector, NB=4, visible one cycle after acceptance.
        in_st[0] = {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        in_inv[0] = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("kat_fwd", {132'b0, out_st_w[0][127:0]}, {132'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        chk("kat_fwd_tag", {259'b0, out_inv_w[0]}, 260'd0);
        chk("kat_fwd_valid", {259'b0, out_valid_w[0]}, 260'd1);
        drain();

        in_st[0] = {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        in_inv[0] = 1'b1; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("kat_inv", {132'b0, out_st_w[0][127:0]}, {132'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
        chk("kat_inv_tag", {259'b0, out_inv_w[0]}, 260'd1);
        drain();

        // NB=8 counting bytes: rows 2 and 3 rotate left by 3 and 4.
        for (int b = 0; b < 32; b++) st8[255-8*b -: 8] = 8'(b);
        r2e = 64'h0e12161a1e02060a;
        r3e = 64'h13171b1f03070b0f;
        in_st[2] = st8; in_inv[2] = 1'b0; in_valid[2] = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("nb8_row2_c%0d", c), {252'b0, out_st_w[2][255-8*(4*c+2) -: 8]}, {252'b0, r2e[63-8*c -: 8]});
            chk($sformatf("nb8_row3_c%0d", c), {252'b0, out_st_w[2][255-8*(4*c+3) -: 8]}, {252'b0, r3e[63-8*c -: 8]});
        end
        fwd8 = out_st_w[2];
        drain();
        in_st[2] = fwd8; in_inv[2] = 1'b1; in_valid[2] = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        chk("nb8_roundtrip", {4'b0, out_st_w[2]}, {4'b0, st8});
        drain();

        // Backpressure: third word held off, then released in order.
        for (int i = 0; i < 3; i++) begin
            in_st[0] = rand256(); in_inv[0] = 1'(i); in_valid[0] = 1'b1;
            tick();
        end
        chk("bp_occ_full", {258'b0, occ_w[0]}, 260'd2);
        chk("bp_in_ready", {259'b0, in_ready_w[0]}, 260'd0);
        out_ready[0] = 1'b1;
        tick();
        chk("full_pop_no_push", {258'b0, occ_w[0]}, 260'd1);
        tick();
        chk("push_pop_steady", {258'b0, occ_w[0]}, 260'd1);
        in_valid[0] = 1'b0;
        tick();
        chk("bp_drained", {258'b0, occ_w[0]}, 260'd0);
        out_ready[0] = 1'b0;

        // Reset with two buffered words and live handshakes.
        in_valid[0] = 1'b1;
        in_st[0] = rand256(); tick();
        in_st[0] = rand256(); tick();
        rst = 1'b1; out_ready[0] = 1'b1;
        tick();
        rst = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        chk("midrst_occ", {258'b0, occ_w[0]}, 260'd0);
        chk("midrst_out_valid", {259'b0, out_valid_w[0]}, 260'd0);
        chk("midrst_in_ready", {259'b0, in_ready_w[0]}, 260'd1);
        chk("midrst_out_state", {132'b0, out_st_w[0][127:0]}, 260'd0);

        // Random mixed-mode streams with random backpressure.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_inv[k]    = 1'($urandom);
                in_st[k]     = rand256();
                out_ready[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        drain();

        // Full-rate streaming: every cycle accepted, occupancy pinned at 1.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k] = 1'b1; out_ready[k] = 1'b1;
                in_inv[k] = 1'($urandom); in_st[k] = rand256();
            end
            tick();
            if (i > 0) chk("stream_occ", {258'b0, occ_w[1]}, 260'd1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 SHALL have parameter NB, default 4: state columns; legal values 4, 6, 8 (Rijndael block 128/192/256 bits).
REQ-002 SHALL have parameter W = 32*NB as a derived localparam: state width in bits.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_state/in_inv are valid.
REQ-007 SHALL have port in_ready, output, 1: the block can accept a word.
REQ-008 SHALL have port in_state, input, W: state to transform.
REQ-009 SHALL have port in_inv, input, 1: 0 = ShiftRows, 1 = InvShiftRows.
REQ-010 SHALL have port out_valid, output, 1: out_state/out_inv are valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream accepts.
REQ-012 SHALL have port out_state, output, W: transformed state.
REQ-013 SHALL have port out_inv, output, 1: the mode tag carried with the word.
REQ-014 SHALL have port occupancy, output, 2: number of buffered words, 0..2.

Function
REQ-015 Byte k SHALL occupy in_state[W-1-8k -: 8]; row r = k mod 4, column c = k div 4 (column-major, FIPS-197 order).
REQ-016 Row shift s(r) SHALL be 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-017 Forward mode SHALL compute out[r][c] = in[r][(c+s(r)) mod NB].
REQ-018 Inverse mode SHALL compute out[r][c] = in[r][(c-s(r)) mod NB], including correct modular wrap for negative indices.
REQ-019 Transfers SHALL occur only when valid and ready are both high on the same rising edge.
REQ-020 The permutation SHALL be applied on entry; the transformed word and its in_inv tag SHALL be stored in a 2-entry FIFO.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_* after edge N when the FIFO was empty.
REQ-022 in_ready SHALL equal (occupancy < 2), be driven from registers only, and have no combinational path from out_ready.
REQ-023 out_valid SHALL equal (occupancy > 0); out_state and out_inv SHALL show the oldest entry.
REQ-024 On a simultaneous accept and emit, occupancy SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-025 When full, in_valid SHALL be ignored; no word is overwritten or dropped.
REQ-026 When empty, out_ready SHALL have no effect; occupancy SHALL not underflow.
REQ-027 While out_valid=1 and out_ready=0, out_state and out_inv SHALL hold stable.
REQ-028 Sustained throughput SHALL be 1 word/cycle when out_ready is held high.
REQ-029 The mode SHALL be selectable per word; mixed-mode streams SHALL be supported with no bubbles.
REQ-030 Any NB outside {4,6,8} SHALL cause elaboration failure.

Reset
REQ-031 With rst=1 at an edge: occupancy=0, out_valid=0, in_ready=1, out_state=0, out_inv=0.
REQ-032 Reset SHALL override simultaneous handshakes; buffered words are discarded, even mid-stream.
REQ-033 Data registers MAY hold their values under reset, except the output-visible head, which SHALL read 0.

Verification
REQ-034 NB=4, fwd: in d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, 1 cycle later.
REQ-035 NB=4, inv: input = REQ-034 output -> out equals REQ-034 input; out_inv=1.
REQ-036 NB=8, fwd: bytes 00..1f (byte k = k) -> row 2 bytes [02,06,...,1e] rotate left 3 and row 3 rotate left 4; fwd then inv round-trips.
REQ-037 Backpressure: out_ready=0, push 3 words -> third held off (in_ready=0 after 2), occupancy=2; release -> 3 words out in order.
REQ-038 Full with simultaneous pop: push and pop same edge -> occupancy stays 2 only if in_ready was 1; no loss, no duplication.
REQ-039 Reset with 2 buffered words -> next cycle occupancy=0, out_valid=0, in_ready=1; random fwd/inv streams match a reference model for NB=4,6,8.
